// File: rtl/training_data_server_pkg.sv
// Shared types for the training data server: FSM state encoding,
// default sample field width and the packed {x1, x2, t} sample record.
package training_data_server_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      VALID   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef struct packed {
      logic signed [DATA_W_DEF-1:0] x1;
      logic signed [DATA_W_DEF-1:0] x2;
      logic signed [DATA_W_DEF-1:0] t;
   } sample_t;

endpackage

// File: rtl/training_data_server_if.sv
// Request/serve handshake, memory load port and status of the training data
// server. Optional epoch-limit signals exist only when
// TRAINING_DATA_SERVER_EPOCH_LIMIT_EN is defined.
interface training_data_server_if
   import training_data_server_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = 4
);
   logic                     req;
   logic                     rewind;
   logic [ADDR_W:0]          num_samples;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic signed [DATA_W-1:0] wr_x1;
   logic signed [DATA_W-1:0] wr_x2;
   logic signed [DATA_W-1:0] wr_t;
   logic                     ready;
   logic signed [DATA_W-1:0] x1;
   logic signed [DATA_W-1:0] x2;
   logic signed [DATA_W-1:0] t;
   logic                     eof;
   logic [ADDR_W-1:0]        idx;
   logic [7:0]               epoch_cnt;
`ifdef TRAINING_DATA_SERVER_EPOCH_LIMIT_EN
   logic [7:0]               epoch_limit;
   logic                     limit_hit;
`endif

   modport master (
`ifdef TRAINING_DATA_SERVER_EPOCH_LIMIT_EN
      output epoch_limit,
      input  limit_hit,
`endif
      output req, rewind, num_samples, wr_en, wr_addr, wr_x1, wr_x2, wr_t,
      input  ready, x1, x2, t, eof, idx, epoch_cnt
   );

   modport slave (
`ifdef TRAINING_DATA_SERVER_EPOCH_LIMIT_EN
      input  epoch_limit,
      output limit_hit,
`endif
      input  req, rewind, num_samples, wr_en, wr_addr, wr_x1, wr_x2, wr_t,
      output ready, x1, x2, t, eof, idx, epoch_cnt
   );

endinterface

// File: rtl/sample_mem.sv
// Sample storage: DEPTH entries of {x1, x2, t}, synchronous write,
// registered read. A same-cycle write to the address being read returns
// the old contents. The array itself is not reset; the read register is.
module sample_mem
   import training_data_server_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [3*DATA_W-1:0]   wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [3*DATA_W-1:0]   rd_data
);

   logic [3*DATA_W-1:0] mem [DEPTH];

   // Storage write, allowed in any cycle.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register; only loads on a fetch so served data holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/training_data_server.sv
// Training data server: serves one stored sample per req high/low cycle,
// walking idx over the active sample count and counting completed epochs.
// Optional feature macro: TRAINING_DATA_SERVER_EPOCH_LIMIT_EN (epoch_limit
// input, sticky limit_hit output that blocks further requests).
module training_data_server
   import training_data_server_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input logic                   clk,
   input logic                   rst,
   training_data_server_if.slave bus
);

   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_IDX   = ADDR_W'(1);

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W:0]     active_q;
   logic [ADDR_W:0]     active_d;
   logic [ADDR_W:0]     last_idx;
   logic [ADDR_W-1:0]   idx_q;
   logic [7:0]          epoch_q;
   logic                eof_q;
   logic                at_last;
   logic                past_last;
   logic                ready_c;
   logic                fetch_en;
   logic                blocked;
   logic [3*DATA_W-1:0] wr_data;
   logic [3*DATA_W-1:0] rd_data;

   assign active_d  = (bus.num_samples == '0 || bus.num_samples > DEPTH_CNT)
                      ? DEPTH_CNT : bus.num_samples;
   assign last_idx  = active_q - ONE_CNT;
   assign at_last   = ({1'b0, idx_q} == last_idx);
   // Wrap also covers an idx left beyond a since-shrunk active count.
   assign past_last = ({1'b0, idx_q} >= last_idx);

`ifdef TRAINING_DATA_SERVER_EPOCH_LIMIT_EN
   logic limit_q;
   logic limit_now;

   // Blocking uses the live comparison as well so a request arriving in the
   // same cycle the limit is reached is already refused.
   assign limit_now = (bus.epoch_limit != 8'd0) && (epoch_q >= bus.epoch_limit);
   assign blocked   = limit_q || limit_now;
   assign bus.limit_hit = limit_q;

   // Sticky limit flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            limit_q <= 1'b0;
      else if (limit_now) limit_q <= 1'b1;
   end
`else
   assign blocked = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: one serve per req high/low cycle; rewind aborts a serve.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req && !blocked) state_nx = FETCH;
         FETCH:   state_nx = VALID;
         VALID:   if (!bus.req) state_nx = RELEASE;
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (bus.rewind && (state == FETCH || state == VALID)) state_nx = IDLE;
   end

   // Outputs decoded from state.
   always_comb begin
      ready_c  = 1'b0;
      fetch_en = 1'b0;
      if (state == VALID)                 ready_c  = 1'b1;
      if (state == FETCH && !bus.rewind) fetch_en = 1'b1;
   end

   // Active count latch, eof capture, index walk and epoch counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= DEPTH_CNT;
         eof_q    <= 1'b0;
         idx_q    <= '0;
         epoch_q  <= '0;
      end else begin
         if (state == IDLE) active_q <= active_d;
         if (fetch_en)      eof_q    <= at_last;
         if (bus.rewind) begin
            idx_q <= '0;
         end else if (state == RELEASE) begin
            if (past_last) begin
               idx_q <= '0;
               if (epoch_q != 8'hFF) epoch_q <= epoch_q + 8'd1;
            end else begin
               idx_q <= idx_q + ONE_IDX;
            end
         end
      end
   end

   assign wr_data = {bus.wr_x1, bus.wr_x2, bus.wr_t};

   sample_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (wr_data),
      .rd_en   (fetch_en),
      .rd_addr (idx_q),
      .rd_data (rd_data)
   );

   assign bus.ready     = ready_c;
   assign bus.x1        = rd_data[3*DATA_W-1 -: DATA_W];
   assign bus.x2        = rd_data[2*DATA_W-1 -: DATA_W];
   assign bus.t         = rd_data[DATA_W-1:0];
   assign bus.eof       = eof_q;
   assign bus.idx       = idx_q;
   assign bus.epoch_cnt = epoch_q;

endmodule

// File: tb/tb_training_data_server.sv
// Bench for training_data_server: directed handshakes with literal
// expectations plus a sample-level model checked whenever ready is high.
module tb_training_data_server;
   import training_data_server_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   sample_t m_mem [16];
   int      m_idx   = 0;
   int      m_n     = 3;
   int      m_epoch = 0;

   training_data_server_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   training_data_server #(.DATA_W(8), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model compare: whenever a sample is presented it must be the model's next one.
   always @(negedge clk) begin
      if (!rst && bus.ready) begin
         chk("mdl_x1",    int'(bus.x1), int'(m_mem[m_idx].x1));
         chk("mdl_x2",    int'(bus.x2), int'(m_mem[m_idx].x2));
         chk("mdl_t",     int'(bus.t),  int'(m_mem[m_idx].t));
         chk("mdl_eof",   int'(bus.eof), (m_idx == m_n - 1) ? 1 : 0);
         chk("mdl_idx",   int'(bus.idx), m_idx);
         chk("mdl_epoch", int'(bus.epoch_cnt), m_epoch);
      end
   end

   task automatic advance();
      if (m_idx + 1 >= m_n) begin
         m_idx = 0;
         if (m_epoch < 255) m_epoch++;
      end else begin
         m_idx++;
      end
   endtask

   task automatic write(input int a, input int v1, input int v2, input int vt);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(a);
      bus.wr_x1   = 8'(v1);
      bus.wr_x2   = 8'(v2);
      bus.wr_t    = 8'(vt);
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      m_mem[a] = '{x1: 8'(v1), x2: 8'(v2), t: 8'(vt)};
   endtask

   task automatic raise_req();
      int lat = 0;
      bus.req = 1'b1;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.ready) break;
      end
      chk("ready_latency", lat, 2);
   endtask

   task automatic chk_data(input int e1, input int e2, input int et, input int ee);
      chk("x1",  int'(bus.x1), e1);
      chk("x2",  int'(bus.x2), e2);
      chk("t",   int'(bus.t),  et);
      chk("eof", int'(bus.eof), ee);
   endtask

   task automatic serve(input int e1, input int e2, input int et, input int ee);
      int n = 0;
      raise_req();
      chk_data(e1, e2, et, ee);
      bus.req = 1'b0;
      while (bus.ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_drop", int'(bus.ready), 0);
      @(posedge clk); #1;
      advance();
   endtask

   initial begin
      int rises;
      logic prev;
      bus.req = 1'b0;
      bus.rewind = 1'b0;
      bus.num_samples = 5'd3;
      bus.wr_en = 1'b0;
      bus.wr_addr = '0;
      bus.wr_x1 = '0;
      bus.wr_x2 = '0;
      bus.wr_t = '0;
`ifdef TRAINING_DATA_SERVER_EPOCH_LIMIT_EN
      bus.epoch_limit = 8'd2;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", int'(bus.ready), 0);
      chk("rst_x1",    int'(bus.x1), 0);
      chk("rst_eof",   int'(bus.eof), 0);
      chk("rst_idx",   int'(bus.idx), 0);
      chk("rst_epoch", int'(bus.epoch_cnt), 0);
      rst = 1'b0;

      // Three samples, one pass.
      write(0, 1, 2, 1);
      write(1, 3, -4, -1);
      write(2, 5, 6, 1);
      serve(1, 2, 1, 0);
      serve(3, -4, -1, 0);
      serve(5, 6, 1, 1);
      chk("epoch_after_pass", int'(bus.epoch_cnt), 1);
      chk("idx_after_pass",   int'(bus.idx), 0);

      // Req held high: exactly one serve.
      rises = 0;
      prev  = 1'b0;
      bus.req = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i == 10) bus.req = 1'b0;
         @(posedge clk); #1;
         if (bus.ready && !prev) rises++;
         prev = bus.ready;
      end
      chk("held_req_rises", rises, 1);
      advance();
      chk("held_req_idx", int'(bus.idx), 1);

      // Rewind while presenting the second sample.
      raise_req();
      chk_data(3, -4, -1, 0);
      bus.rewind = 1'b1;
      bus.req    = 1'b0;
      @(posedge clk); #1;
      bus.rewind = 1'b0;
      chk("rewind_ready", int'(bus.ready), 0);
      chk("rewind_idx",   int'(bus.idx), 0);
      m_idx = 0;
      serve(1, 2, 1, 0);
      chk("rewind_epoch", int'(bus.epoch_cnt), 1);

      // Rewind coincident with release of the last sample.
      serve(3, -4, -1, 0);
      raise_req();
      chk_data(5, 6, 1, 1);
      bus.req = 1'b0;
      @(posedge clk); #1;
      bus.rewind = 1'b1;
      @(posedge clk); #1;
      bus.rewind = 1'b0;
      chk("rew_rel_idx",   int'(bus.idx), 0);
      chk("rew_rel_epoch", int'(bus.epoch_cnt), 1);
      m_idx = 0;

      // Reset during FETCH: outputs clear without waiting for a clock edge.
      bus.req = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready", int'(bus.ready), 0);
      chk("midrst_x1",    int'(bus.x1), 0);
      chk("midrst_x2",    int'(bus.x2), 0);
      chk("midrst_t",     int'(bus.t), 0);
      chk("midrst_eof",   int'(bus.eof), 0);
      chk("midrst_idx",   int'(bus.idx), 0);
      chk("midrst_epoch", int'(bus.epoch_cnt), 0);
      bus.req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_idx = 0;
      m_epoch = 0;
      serve(1, 2, 1, 0);

`ifdef TRAINING_DATA_SERVER_EPOCH_LIMIT_EN
      serve(3, -4, -1, 0);
      serve(5, 6, 1, 1);
      serve(1, 2, 1, 0);
      serve(3, -4, -1, 0);
      serve(5, 6, 1, 1);
      @(posedge clk); #1;
      chk("limit_hit",   int'(bus.limit_hit), 1);
      chk("limit_epoch", int'(bus.epoch_cnt), 2);
      rises = 0;
      bus.req = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.ready) rises++;
      end
      bus.req = 1'b0;
      chk("limit_blocks_req", rises, 0);
      bus.epoch_limit = 8'd0;
`endif

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_idx = 0;
      m_epoch = 0;

      // Single-sample set: write to the address being fetched returns old data.
      bus.num_samples = 5'd1;
      m_n = 1;
      @(posedge clk); #1;
      bus.req = 1'b1;
      @(posedge clk); #1;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd0;
      bus.wr_x1   = 8'd7;
      bus.wr_x2   = -8'sd8;
      bus.wr_t    = -8'sd1;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      chk("wr_fetch_ready", int'(bus.ready), 1);
      chk_data(1, 2, 1, 1);
      bus.req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      advance();
      m_mem[0] = '{x1: 8'sd7, x2: -8'sd8, t: -8'sd1};
      chk("single_epoch", int'(bus.epoch_cnt), 1);

      // Epoch counter saturation.
      for (int i = 0; i < 256; i++) serve(7, -8, -1, 1);
      chk("epoch_saturate", int'(bus.epoch_cnt), 255);
      chk("sat_idx",        int'(bus.idx), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/training_data_server.md
TRAINING_DATA_SERVER -- requirements
Module: training_data_server

Interface
REQ-001 Parameter DATA_W, default 8: width of each signed sample field x1, x2 and target t.
REQ-002 Parameter DEPTH, default 16: sample-memory entries; ADDR_W = clog2(DEPTH), default 4.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  level request for the next sample; held high until ready is seen.
REQ-006 rewind  input  1  synchronous pulse; next sample served is index 0.
REQ-007 num_samples  input  ADDR_W+1  active sample count, 1..DEPTH; sampled only while state is IDLE.
REQ-008 wr_en  input  1  memory write strobe.
REQ-009 wr_addr  input  ADDR_W  write index.
REQ-010 wr_x1, wr_x2, wr_t  input  DATA_W each  write data.
REQ-011 ready  output  1  x1/x2/t/eof are valid.
REQ-012 x1, x2, t  output  DATA_W each  served sample, registered.
REQ-013 eof  output  1  served sample is the last active sample (index num_samples-1).
REQ-014 idx  output  ADDR_W  index of the sample currently or next served.
REQ-015 epoch_cnt  output  8  completed passes over the sample set; saturates at 255.

Function
REQ-016 FSM states IDLE, FETCH, VALID, RELEASE; IDLE->FETCH when req=1; FETCH->VALID unconditionally; VALID->RELEASE when req=0; RELEASE->IDLE unconditionally.
REQ-017 FETCH reads memory at idx; x1/x2/t/eof are registered at the end of FETCH; ready=1 only in VALID; first ready is 2 cycles after req is first sampled high.
REQ-018 x1/x2/t/eof hold stable throughout VALID, and after it until the next FETCH completes.
REQ-019 In RELEASE, idx advances by 1; if idx was num_samples-1, idx wraps to 0 and epoch_cnt increments (saturating).
REQ-020 req remaining high in IDLE after RELEASE starts a new fetch; one sample is served per req high/low cycle, never two.
REQ-021 rewind sets idx to 0 in any state and does not change epoch_cnt; in FETCH or VALID it forces the state to IDLE, with ready=0 the following cycle.
REQ-022 rewind and RELEASE in the same cycle: rewind wins, idx=0, and epoch_cnt does not increment.
REQ-023 wr_en writes the memory in any state; a write to the address being fetched in the same cycle returns the old data.
REQ-024 An active count latched as 0 or greater than DEPTH is treated as DEPTH.
REQ-025 eof = (idx == active count - 1), computed at fetch time.

Reset
REQ-026 rst forces state IDLE; ready=0, x1=x2=t=0, eof=0, idx=0, epoch_cnt=0, and limit_hit=0 when present.
REQ-027 Memory contents are not reset.
REQ-028 rst mid-handshake drops ready asynchronously; the bench re-issues req after release.

Configuration
REQ-029 Macro TRAINING_DATA_SERVER_EPOCH_LIMIT_EN adds:
- input epoch_limit (8 bits);
- output limit_hit (1 bit), set when epoch_cnt reaches epoch_limit (nonzero) and cleared only by rst.
REQ-030 While limit_hit=1, req is ignored: the FSM stays in IDLE and ready stays 0.
REQ-031 Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Structure
REQ-032 A shared package holds:
- the FSM state enum (IDLE=0, FETCH=1, VALID=2, RELEASE=3);
- the DATA_W default;
- the sample struct {x1, x2, t}.
REQ-033 One sub-module, sample_mem: DEPTH x 3*DATA_W, synchronous write, registered read.

Verification
REQ-034 Load 3 samples {(1,2,1),(3,-4,-1),(5,6,1)}, num_samples=3, pulse req three times:
- ready rises 2 cycles after each req;
- data matches in order;
- eof=1 only on the third sample;
- epoch_cnt=1 afterwards.
REQ-035 Hold req high for 10 cycles: exactly one ready assertion occurs, and no second serve happens until req falls.
REQ-036 Pulse rewind while in VALID on sample 2: ready drops the next cycle; the next req returns sample 0 and epoch_cnt is unchanged.
REQ-037 Apply rewind coincident with RELEASE of the last sample: idx=0 and epoch_cnt is not incremented.
REQ-038 With the macro, epoch_limit=2 and 3 samples: after 6 serves limit_hit=1, and a further req gives no ready for 20 cycles.
REQ-039 Assert rst during FETCH: all outputs return to reset values immediately; after release, req serves sample 0.
